// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mul_div_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(ITER) + 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [63:0]   acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0]   opnd;     // multiplicand or divisor magnitude
    logic          is_div;
    logic          neg_res;  // operand signs differ (product / quotient negate)
    logic          neg_rem;  // dividend negative (remainder negate)
    logic          b_zero;

    logic          accept;
    logic          op_signed;
    logic [31:0]   a_mag, b_mag;
    logic [32:0]   add_sum, sub_trial;
    logic [63:0]   acc_step, prod;
    logic [31:0]   quo, rem;
    logic [31:0]   res_hi, res_lo;

    // Handshake and status outputs follow directly from the state.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        accept    = req_valid && (state == IDLE);
    end

    // Operand magnitudes for the signed opcodes (MULT=000, DIV=010).
    always_comb begin
        op_signed = ~req_op[0];
        a_mag     = (op_signed && A[31]) ? -A : A;
        b_mag     = (op_signed && B[31]) ? -B : B;
    end

    // One shift-add (multiply) or restoring-subtract (divide) step per cycle.
    always_comb begin
        add_sum   = {1'b0, acc[63:32]} + {1'b0, opnd};
        sub_trial = acc[63:31] - {1'b0, opnd};
        acc_step  = acc;
        if (is_div) begin
            if (sub_trial[32]) begin
                acc_step = {acc[62:0], 1'b0};
            end else begin
                acc_step = {sub_trial[31:0], acc[30:0], 1'b1};
            end
        end else begin
            if (acc[0]) begin
                acc_step = {add_sum, acc[31:1]};
            end else begin
                acc_step = {1'b0, acc[63:1]};
            end
        end
    end

    // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient.
    always_comb begin
        prod   = neg_res ? -acc : acc;
        quo    = acc[31:0];
        rem    = acc[63:32];
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            res_hi = neg_rem ? -rem : rem;
            if (b_zero) begin
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_lo = neg_res ? -quo : quo;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush always wins and returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !req_op[2]) state_nxt = CALC;
            CALC: if (cnt == CW'(ITER - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Datapath, iteration counter, HI/LO and the done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !flush) begin
                        cnt <= '0;
                        case (req_op)
                            3'b100: begin
                                hi   <= A;
                                done <= 1'b1;
                            end
                            3'b101: begin
                                lo   <= A;
                                done <= 1'b1;
                            end
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                acc     <= {32'b0, a_mag};
                                opnd    <= b_mag;
                                is_div  <= req_op[1];
                                neg_res <= op_signed && (A[31] ^ B[31]);
                                neg_rem <= op_signed && A[31];
                                b_zero  <= (B == 32'b0);
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mul_div_unit #(.ITER(ITER)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .A         (A),
        .B         (B),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: plain arithmetic on the architectural definitions.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, p;
        int     da, db;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        da = $signed(a);
        db = $signed(b);
        h = '0;
        l = '0;
        case (op)
            3'b000: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            3'b001: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
            3'b010: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 0; l = 32'h8000_0000; end
                else begin l = da / db; h = da % db; end
            end
            3'b011: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin l = a / b; h = a % b; end
            end
            default: ;
        endcase
    endfunction

    // Present one request for exactly one accepting edge; returns at edge+1.
    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic expect_no_done(input string tag, input int n);
        bit saw = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done) saw = 1;
        end
        check(tag, 64'(saw), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit poke);
        int k = 0;
        start(op, a, b);
        check({tag, "_busy"}, 64'(busy), 64'(1));
        while (done !== 1'b1 && k < ITER + 20) begin
            if (poke && k == 5) begin
                req_valid = 1'b1;
                req_op = 3'b101;
                A = 32'h1111_1111;
            end
            if (poke && k == 6) check({tag, "_ready_in_calc"}, 64'(req_ready), 64'(0));
            if (poke && k == 7) req_valid = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        req_valid = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'(ITER + 1));
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        exp_hi = eh;
        exp_lo = el;
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb, mh, ml;

        // Reset state
        #2 resetn = 1'b0;
        #2;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(1));
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;

        // Directed arithmetic vectors
        run_op("multu_7x6", 3'b001, 32'd7, 32'd6, 32'h0, 32'h2A, 0);
        run_op("mult_m2x3", 3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_op("multu_m2x3", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'h2, 32'hFFFF_FFFA, 0);
        run_op("div_m7d2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu_100d7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op("divu_by0", 3'b011, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 0);
        run_op("div_by0_neg", 3'b010, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);

        // MTHI while idle
        start(3'b100, 32'hDEAD_BEEF, 32'h0);
        check("mthi_hi", 64'(hi), 64'(32'hDEAD_BEEF));
        check("mthi_lo_kept", 64'(lo), 64'(exp_lo));
        check("mthi_done", 64'(done), 64'(1));
        exp_hi = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("mthi_done_pulse", 64'(done), 64'(0));

        // req_valid (MTLO) while busy is ignored
        run_op("mult_poke", 3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);

        // Flush at cycle 10 of a MULT
        start(3'b000, 32'd12345, 32'd678);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush10_ready", 64'(req_ready), 64'(1));
        check("flush10_busy", 64'(busy), 64'(0));
        expect_no_done("flush10_nodone", ITER + 8);
        check("flush10_hilo", {hi, lo}, {exp_hi, exp_lo});

        // Flush on the accepting edge of an MTLO
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b101; A = 32'hCAFE_F00D; flush = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        check("flush_mt_lo", 64'(lo), 64'(exp_lo));
        expect_no_done("flush_mt_nodone", 3);

        // Flush during FIX
        start(3'b001, 32'd9, 32'd9);
        repeat (ITER) @(posedge clk);
        #1;
        check("fix_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("fixflush_done", 64'(done), 64'(0));
        check("fixflush_hilo", {hi, lo}, {exp_hi, exp_lo});
        check("fixflush_ready", 64'(req_ready), 64'(1));
        expect_no_done("fixflush_nodone", 4);

        // Reserved opcode: accepted, no effect
        start(3'b110, 32'h5555_5555, 32'h1);
        check("rsvd_ready", 64'(req_ready), 64'(1));
        expect_no_done("rsvd_nodone", ITER + 4);
        check("rsvd_hilo", {hi, lo}, {exp_hi, exp_lo});

        // Reset during CALC
        start(3'b000, 32'd77, 32'd88);
        repeat (4) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_hilo", {hi, lo}, 64'(0));
        check("midrst_ready", 64'(req_ready), 64'(1));
        @(negedge clk) resetn = 1'b1;
        expect_no_done("midrst_nodone", ITER + 8);
        exp_hi = 0;
        exp_lo = 0;

        // First request accepted on the first edge after release
        @(negedge clk) resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1; req_valid = 1'b1; req_op = 3'b101; A = 32'h0BAD_CAFE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("first_req_lo", 64'(lo), 64'(32'h0BAD_CAFE));
        check("first_req_done", 64'(done), 64'(1));
        exp_lo = 32'h0BAD_CAFE;

        // Randomized arithmetic against the reference model
        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 0;
                1: rb = 32'($urandom_range(1, 20));
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            model(rop, ra, rb, mh, ml);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, mh, ml, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  unit can accept a request (IDLE state).
- req_op  in  3  opcode: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved.
- A  in  32  rs operand (multiplicand / dividend / MTHI-MTLO source).
- B  in  32  rt operand (multiplier / divisor).
- flush  in  1  pipeline cancel; aborts the in-flight operation.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse; HI/LO updated this cycle.
- hi  out  32  HI register.
- lo  out  32  LO register.

REQ-002 SHALL have parameter ITER, default 32, meaning the number of iteration cycles per multiply or divide.

Function
REQ-003 SHALL implement states IDLE, CALC and FIX.
REQ-004 A request SHALL be accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-005 req_ready SHALL be 1 only in IDLE; busy SHALL be 1 in CALC and FIX.
REQ-006 An accepted MTHI or MTLO SHALL write A to hi or lo on the accepting edge, stay in IDLE, and pulse done the next cycle.
REQ-007 An accepted MULT, MULTU, DIV or DIVU SHALL latch its operands and go IDLE -> CALC.
REQ-008 CALC SHALL run for exactly ITER cycles, processing one bit per cycle, then go CALC -> FIX.
REQ-009 FIX SHALL apply the sign correction, write hi/lo, assert done, and go FIX -> IDLE.
REQ-010 Latency SHALL be fixed: accept at edge T, done high during cycle T+ITER+1, hi/lo valid from that same cycle.
REQ-011 Multiply SHALL use shift-add on operand magnitudes; signed MULT negates the 64-bit product when the operand signs differ.
REQ-012 Multiply results: hi = product[63:32], lo = product[31:0].
REQ-013 Divide SHALL use restoring division on operand magnitudes; the quotient truncates toward zero.
REQ-014 Signed DIV: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
REQ-015 Divide results: lo = quotient, hi = remainder.
REQ-016 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000, hi = 0 with no exception.
REQ-017 Divide by zero (B = 0) SHALL use the normal latency and yield lo = 0xFFFFFFFF, hi = A (signed and unsigned alike).
REQ-018 Reserved opcodes SHALL be accepted, cause no state change, and produce no done.
REQ-019 flush SHALL return the unit to IDLE on the next edge with hi/lo unchanged and no done pulse.
REQ-020 flush asserted in the same cycle as an accepting edge SHALL cancel that request, including MTHI/MTLO.
REQ-021 flush asserted during FIX SHALL suppress the hi/lo write and the done pulse.
REQ-022 hi/lo SHALL change only on an MTHI/MTLO write or in FIX.
REQ-023 req_valid while busy SHALL be ignored; operands SHALL not be resampled during CALC/FIX.

Reset
REQ-024 resetn low SHALL immediately force: state IDLE, hi = 0, lo = 0, done = 0, busy = 0, req_ready = 1, iteration counter = 0.
REQ-025 Reset mid-operation SHALL abandon the operation with no done pulse after release.
REQ-026 The first request SHALL be accepted on the first rising edge after resetn deasserts.

Verification
REQ-027 MULTU A=7, B=6 -> done at T+33, hi = 0x00000000, lo = 0x0000002A.
REQ-028 MULT A=0xFFFFFFFE, B=3 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; MULTU same operands -> hi = 0x00000002, lo = 0xFFFFFFFA.
REQ-029 DIV A=0xFFFFFFF9, B=2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU A=100, B=7 -> lo = 14, hi = 2.
REQ-030 DIVU A=0x1234, B=0 -> lo = 0xFFFFFFFF, hi = 0x00001234 at T+33; DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-031 MTHI A=0xDEADBEEF while IDLE -> hi = 0xDEADBEEF after the accepting edge, done next cycle, lo unchanged; req_valid during CALC -> ignored.
REQ-032 MULT started, flush at cycle 10 -> IDLE next edge, hi/lo keep prior values, no done.
REQ-033 MULT started, resetn low at cycle 5 -> hi = lo = 0, req_ready = 1, no done after release.
